// File: rtl/joint_pos_pkg.sv
// ============================================================================
// Module      : joint_pos_pkg
// Description : Shared channel FSM state encoding and default timing values
//               for the joint position counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package joint_pos_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } joint_state_t;

    localparam int DEFAULT_NUM_CH        = 4;
    localparam int DEFAULT_WIDTH         = 8;
    localparam int DEFAULT_HOLD_CYCLES   = 1000000;
    localparam int DEFAULT_REPEAT_CYCLES = 200000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/joint_pos_channel.sv
// ============================================================================
// Module      : joint_pos_channel
// Description : One joint channel: saturating position register with
//               press / hold / auto-repeat stepping and a clamped load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module joint_pos_channel
    import joint_pos_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int POS_INIT      = 2**(WIDTH-1),
    parameter int POS_MIN       = 0,
    parameter int POS_MAX       = 2**WIDTH-1,
    parameter int STEP          = 1,
    parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_up,
    input  logic             cnt_down,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] pos,
    output logic             at_min,
    output logic             at_max,
    output logic             moved
);

    localparam int c_timer_max = max_int(HOLD_CYCLES, REPEAT_CYCLES);
    localparam int c_tw        = (c_timer_max > 1) ? $clog2(c_timer_max) : 1;

    localparam logic [c_tw-1:0]  c_hold_last = c_tw'(HOLD_CYCLES - 1);
    localparam logic [c_tw-1:0]  c_rep_last  = c_tw'(REPEAT_CYCLES - 1);
    localparam logic [c_tw-1:0]  c_tmr_zero  = '0;
    localparam logic [c_tw-1:0]  c_tmr_one   = c_tw'(1);
    localparam logic [WIDTH:0]   c_min_x     = (WIDTH+1)'(POS_MIN);
    localparam logic [WIDTH:0]   c_max_x     = (WIDTH+1)'(POS_MAX);
    localparam logic [WIDTH:0]   c_step_x    = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] c_min       = WIDTH'(POS_MIN);
    localparam logic [WIDTH-1:0] c_max       = WIDTH'(POS_MAX);
    localparam logic [WIDTH-1:0] c_init      = WIDTH'(POS_INIT);
    localparam logic             c_init_min  = (c_init == c_min);
    localparam logic             c_init_max  = (c_init == c_max);

    joint_state_t     r_state;
    logic [c_tw-1:0]  r_timer;
    logic             r_dir;
    logic [WIDTH-1:0] r_pos;
    logic             r_at_min;
    logic             r_at_max;
    logic             r_moved;

    joint_state_t     w_state_nxt;
    logic [c_tw-1:0]  w_timer_nxt;
    logic             w_dir_nxt;
    logic [WIDTH-1:0] w_pos_nxt;
    logic             w_fresh;
    logic             w_step;
    logic             w_up_req;
    logic             w_dn_req;
    logic             w_req;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_load_x;
    logic [WIDTH-1:0] w_up_pos;
    logic [WIDTH-1:0] w_dn_pos;
    logic [WIDTH-1:0] w_load_pos;

    assign w_up_req = cnt_up & ~cnt_down;
    assign w_dn_req = cnt_down & ~cnt_up;
    assign w_req    = w_up_req | w_dn_req;

    // One extra bit keeps the overflow/underflow visible so the result saturates
    assign w_sum    = {1'b0, r_pos} + c_step_x;
    assign w_diff   = {1'b0, r_pos} - c_step_x;
    assign w_up_pos = (w_sum > c_max_x) ? c_max : w_sum[WIDTH-1:0];
    assign w_dn_pos = (w_diff[WIDTH] || (w_diff < c_min_x)) ? c_min : w_diff[WIDTH-1:0];

    assign w_load_x   = {1'b0, load_val};
    assign w_load_pos = (w_load_x < c_min_x) ? c_min :
                        (w_load_x > c_max_x) ? c_max : load_val;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_dir_nxt   = r_dir;
        w_pos_nxt   = r_pos;
        w_fresh     = 1'b0;
        w_step      = 1'b0;
        if (load_en) begin
            w_pos_nxt   = w_load_pos;
            w_state_nxt = ST_IDLE;
            w_timer_nxt = c_tmr_zero;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) w_fresh = 1'b1;
                end
                ST_HOLD, ST_REPEAT: begin
                    if (!w_req) begin
                        w_state_nxt = ST_IDLE;
                        w_timer_nxt = c_tmr_zero;
                    end else if (w_up_req != r_dir) begin
                        // Reversal is treated as a brand-new press
                        w_fresh = 1'b1;
                    end else if (r_timer == ((r_state == ST_HOLD) ? c_hold_last : c_rep_last)) begin
                        w_step      = 1'b1;
                        w_timer_nxt = c_tmr_zero;
                        w_state_nxt = ST_REPEAT;
                    end else begin
                        w_timer_nxt = r_timer + c_tmr_one;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = c_tmr_zero;
                end
            endcase
            if (w_fresh) begin
                w_step      = 1'b1;
                w_dir_nxt   = w_up_req;
                w_timer_nxt = c_tmr_zero;
                w_state_nxt = ST_HOLD;
            end
            if (w_step) w_pos_nxt = w_dir_nxt ? w_up_pos : w_dn_pos;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_timer  <= c_tmr_zero;
            r_dir    <= 1'b1;
            r_pos    <= c_init;
            r_at_min <= c_init_min;
            r_at_max <= c_init_max;
            r_moved  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_dir    <= w_dir_nxt;
            r_pos    <= w_pos_nxt;
            r_at_min <= (w_pos_nxt == c_min);
            r_at_max <= (w_pos_nxt == c_max);
            r_moved  <= (w_pos_nxt != r_pos);
        end
    end

    assign pos    = r_pos;
    assign at_min = r_at_min;
    assign at_max = r_at_max;
    assign moved  = r_moved;

endmodule

`default_nettype wire

// File: rtl/joint_position_counter.sv
// ============================================================================
// Module      : joint_position_counter
// Description : Array of independent saturating joint position counters
//               sharing a single load value bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module joint_position_counter
    import joint_pos_pkg::*;
#(
    parameter int NUM_CH        = DEFAULT_NUM_CH,
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int POS_INIT      = 2**(WIDTH-1),
    parameter int POS_MIN       = 0,
    parameter int POS_MAX       = 2**WIDTH-1,
    parameter int STEP          = 1,
    parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       cnt_up,
    input  logic [NUM_CH-1:0]       cnt_down,
    input  logic [NUM_CH-1:0]       load_en,
    input  logic [WIDTH-1:0]        load_val,
    output logic [NUM_CH*WIDTH-1:0] pos,
    output logic [NUM_CH-1:0]       at_min,
    output logic [NUM_CH-1:0]       at_max,
    output logic [NUM_CH-1:0]       moved
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            joint_pos_channel #(
                .WIDTH         (WIDTH),
                .POS_INIT      (POS_INIT),
                .POS_MIN       (POS_MIN),
                .POS_MAX       (POS_MAX),
                .STEP          (STEP),
                .HOLD_CYCLES   (HOLD_CYCLES),
                .REPEAT_CYCLES (REPEAT_CYCLES)
            ) u_channel (
                .clk      (clk),
                .rst      (rst),
                .cnt_up   (cnt_up[gi]),
                .cnt_down (cnt_down[gi]),
                .load_en  (load_en[gi]),
                .load_val (load_val),
                .pos      (pos[gi*WIDTH +: WIDTH]),
                .at_min   (at_min[gi]),
                .at_max   (at_max[gi]),
                .moved    (moved[gi])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_joint_position_counter.sv
// ============================================================================
// Module      : tb_joint_position_counter
// Description : Scoreboard bench: expected moves and quiet-cycle snapshots
//               are queued by the driver and checked by a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_joint_position_counter;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [1:0]  cnt_up   = 2'b00;
    logic [1:0]  cnt_down = 2'b00;
    logic [1:0]  load_en  = 2'b00;
    logic [7:0]  load_val = 8'd0;
    logic [15:0] pos;
    logic [1:0]  at_min;
    logic [1:0]  at_max;
    logic [1:0]  moved;

    typedef struct {
        int          cyc;
        logic [1:0]  mv;
        logic [15:0] pos;
        logic [1:0]  amin;
        logic [1:0]  amax;
    } exp_t;

    exp_t mq[$];
    exp_t sq[$];
    int   cyc_cnt  = 0;
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    joint_position_counter #(
        .NUM_CH        (2),
        .WIDTH         (8),
        .STEP          (1),
        .HOLD_CYCLES   (4),
        .REPEAT_CYCLES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cnt_up   (cnt_up),
        .cnt_down (cnt_down),
        .load_en  (load_en),
        .load_val (load_val),
        .pos      (pos),
        .at_min   (at_min),
        .at_max   (at_max),
        .moved    (moved)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic exp_t mk(int c, logic [1:0] mv, logic [7:0] p0, logic [7:0] p1);
        exp_t e;
        e.cyc  = c;
        e.mv   = mv;
        e.pos  = {p1, p0};
        e.amin = {p1 == 8'd0,   p0 == 8'd0};
        e.amax = {p1 == 8'hFF,  p0 == 8'hFF};
        return e;
    endfunction

    // Move expected d edges after the current drive point
    task automatic exp_move(int d, logic [1:0] mv, logic [7:0] p0, logic [7:0] p1);
        mq.push_back(mk(cyc_cnt + d, mv, p0, p1));
    endtask

    task automatic exp_snap(logic [7:0] p0, logic [7:0] p1);
        sq.push_back(mk(cyc_cnt, 2'b00, p0, p1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sq.size() > 0 && sq[0].cyc <= cyc_cnt) begin
            e = sq.pop_front();
            checks++;
            if (e.cyc != cyc_cnt || moved !== e.mv || pos !== e.pos ||
                at_min !== e.amin || at_max !== e.amax) begin
                failures++;
                $display("FAIL snapshot cyc=%0d got moved=%b pos=%h at_min=%b at_max=%b, expected cyc=%0d moved=%b pos=%h at_min=%b at_max=%b",
                         cyc_cnt, moved, pos, at_min, at_max, e.cyc, e.mv, e.pos, e.amin, e.amax);
            end
        end
        if (moved !== 2'b00) begin
            checks++;
            if (mq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_move cyc=%0d got moved=%b pos=%h, expected no move",
                         cyc_cnt, moved, pos);
            end else begin
                e = mq.pop_front();
                if (e.cyc != cyc_cnt || moved !== e.mv || pos !== e.pos ||
                    at_min !== e.amin || at_max !== e.amax) begin
                    failures++;
                    $display("FAIL move cyc=%0d got moved=%b pos=%h at_min=%b at_max=%b, expected cyc=%0d moved=%b pos=%h at_min=%b at_max=%b",
                             cyc_cnt, moved, pos, at_min, at_max, e.cyc, e.mv, e.pos, e.amin, e.amax);
                end
            end
        end
        if (done) begin
            checks++;
            if (mq.size() != 0 || sq.size() != 0) begin
                failures++;
                $display("FAIL drain got pending_moves=%0d pending_snaps=%0d, expected 0 and 0",
                         mq.size(), sq.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout at cyc=%0d, expected completion", cyc_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        tick(); tick();
        exp_snap(8'd128, 8'd128);
        tick();
        rst = 1'b0;
        tick();

        // Single-cycle up pulse on channel 0
        cnt_up = 2'b01; exp_move(1, 2'b01, 8'd129, 8'd128);
        tick(); cnt_up = 2'b00;
        tick(); tick();
        exp_snap(8'd129, 8'd128);
        tick();

        load_en = 2'b01; load_val = 8'd128; exp_move(1, 2'b01, 8'd128, 8'd128);
        tick(); load_en = 2'b00;
        tick();

        // Held up for 10 cycles: steps at 0, 4, 6, 8
        cnt_up = 2'b01;
        exp_move(1, 2'b01, 8'd129, 8'd128);
        exp_move(5, 2'b01, 8'd130, 8'd128);
        exp_move(7, 2'b01, 8'd131, 8'd128);
        exp_move(9, 2'b01, 8'd132, 8'd128);
        repeat (10) tick();
        cnt_up = 2'b00;
        tick();
        exp_snap(8'd132, 8'd128);
        tick();

        // Channel 1 to 1, then held down saturates at 0
        load_en = 2'b10; load_val = 8'd1; exp_move(1, 2'b10, 8'd132, 8'd1);
        tick(); load_en = 2'b00;
        cnt_down = 2'b10; exp_move(1, 2'b10, 8'd132, 8'd0);
        repeat (10) tick();
        cnt_down = 2'b00;
        tick();
        exp_snap(8'd132, 8'd0);
        tick();

        // Upper limit: held up at 255 must not move
        load_en = 2'b01; load_val = 8'd255; exp_move(1, 2'b01, 8'd255, 8'd0);
        tick(); load_en = 2'b00;
        cnt_up = 2'b01;
        repeat (6) tick();
        cnt_up = 2'b00;
        tick();
        exp_snap(8'd255, 8'd0);
        tick();

        load_en = 2'b01; load_val = 8'd128; exp_move(1, 2'b01, 8'd128, 8'd0);
        tick(); load_en = 2'b00;
        tick();

        // Both directions high: no request
        cnt_up = 2'b01; cnt_down = 2'b01;
        repeat (5) tick();
        cnt_up = 2'b00; cnt_down = 2'b00;
        tick();
        exp_snap(8'd128, 8'd0);
        cnt_up = 2'b01; exp_move(1, 2'b01, 8'd129, 8'd0);
        tick(); cnt_up = 2'b00;
        tick();

        // Load and up request together: load wins
        load_en = 2'b01; load_val = 8'd50; cnt_up = 2'b01;
        exp_move(1, 2'b01, 8'd50, 8'd0);
        tick(); load_en = 2'b00; cnt_up = 2'b00;
        tick();
        exp_snap(8'd50, 8'd0);
        tick();

        // Reset in the middle of auto-repeat, request held across release
        load_en = 2'b01; load_val = 8'd128; exp_move(1, 2'b01, 8'd128, 8'd0);
        tick(); load_en = 2'b00;
        tick();
        cnt_up = 2'b01;
        exp_move(1, 2'b01, 8'd129, 8'd0);
        exp_move(5, 2'b01, 8'd130, 8'd0);
        exp_move(7, 2'b01, 8'd131, 8'd0);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        exp_snap(8'd128, 8'd128);
        rst = 1'b0; exp_move(1, 2'b01, 8'd129, 8'd128);
        tick(); cnt_up = 2'b00;
        tick(); tick(); tick();
        done = 1'b1;
    end

endmodule

`default_nettype wire
